// File: rtl/dev_packer_rr_pkg.sv
// rtl/dev_packer_rr_pkg.sv - shared types and round-robin helper for the beat packer
package dev_pkg;

    localparam int unsigned MAX_SRC = 32;
    localparam int unsigned MAX_W   = 5;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t COLLECT = 2'd1;
    localparam state_t HOLD    = 2'd2;

    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First requester after 'last', wrapping; the smallest offset wins.
    function automatic int unsigned rr_pick(input logic [MAX_SRC-1:0] req,
                                            input int unsigned last,
                                            input int unsigned n);
        int unsigned idx;
        rr_pick = 0;
        for (int unsigned k = MAX_SRC; k >= 1; k--) begin
            if (k <= n) begin
                idx = last + k;
                if (idx >= n) idx = idx - n;
                if (req[idx[MAX_W-1:0]]) rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/dev_packer_rr_if.sv
// rtl/dev_packer_rr_if.sv - producer/consumer bundle of the beat packer
interface dev_packer_rr_if #(
    parameter int IN_W    = 8,
    parameter int BEATS   = 8,
    parameter int NUM_SRC = 2
);
    import dev_pkg::*;

    localparam int OUT_W = IN_W * BEATS;
    localparam int SRC_W = src_width(NUM_SRC);

    logic [NUM_SRC-1:0]      src_valid;
    logic [NUM_SRC*IN_W-1:0] src_data;
    logic [NUM_SRC-1:0]      src_take;
    logic [NUM_SRC-1:0]      src_done;
    logic [OUT_W-1:0]        sharedBus64;
    logic [SRC_W-1:0]        frame_src;
    logic                    readyB;
    logic                    acceptedC;
    logic                    err_abort;

    modport master (
        input  src_valid, src_data, acceptedC,
        output src_take, src_done, sharedBus64, frame_src, readyB, err_abort
    );

    modport slave (
        output src_valid, src_data, acceptedC,
        input  src_take, src_done, sharedBus64, frame_src, readyB, err_abort
    );

endinterface

// File: rtl/dev_packer_rr_arbiter.sv
// rtl/dev_packer_rr_arbiter.sv - combinational round-robin grant selection
module rr_arbiter
    import dev_pkg::*;
#(
    parameter int NUM_SRC = 2
) (
    input  logic [NUM_SRC-1:0]             req,
    input  logic [src_width(NUM_SRC)-1:0]  last,
    output logic [src_width(NUM_SRC)-1:0]  grant,
    output logic                           any_req
);

    localparam int SRC_W = src_width(NUM_SRC);

    logic [MAX_SRC-1:0] req_ext;

    always_comb begin
        req_ext              = '0;
        req_ext[NUM_SRC-1:0] = req;
    end

    assign any_req = |req;

    if (NUM_SRC == 1) begin : g_single
        assign grant = '0;
    end else begin : g_rr
        assign grant = SRC_W'(rr_pick(req_ext, 32'(last), NUM_SRC));
    end

endmodule

// File: rtl/dev_packer_rr.sv
// rtl/dev_packer_rr.sv - round-robin multi-source narrow-beat to wide-word packer
module dev_packer_rr
    import dev_pkg::*;
#(
    parameter int IN_W      = 8,
    parameter int BEATS     = 8,
    parameter int NUM_SRC   = 2,
    parameter int ABORT_CYC = 16
) (
    input  logic          clkB,
    input  logic          rst,
    dev_packer_rr_if.master bus
);

    localparam int OUT_W   = IN_W * BEATS;
    localparam int SRC_W   = src_width(NUM_SRC);
    localparam int BCNT_W  = $clog2(BEATS + 1);
    localparam int STALL_W = (ABORT_CYC > 0) ? $clog2(ABORT_CYC + 1) : 1;

    state_t               state_q, state_d;
    logic [SRC_W-1:0]     gnt_q, gnt_d;
    logic [SRC_W-1:0]     rr_last_q, rr_last_d;
    logic [SRC_W-1:0]     frame_src_q, frame_src_d;
    logic [BCNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [OUT_W-1:0]     shift_q, shift_d;
    logic [OUT_W-1:0]     out_q, out_d;
    logic                 ready_q, ready_d;
    logic                 abort_q, abort_d;
    logic [NUM_SRC-1:0]   done_q, done_d;
    logic [NUM_SRC-1:0]   take;

    logic [SRC_W-1:0]     arb_grant;
    logic                 arb_any;
    logic [IN_W-1:0]      beats [NUM_SRC];
    logic [IN_W-1:0]      beat;
    logic                 beat_valid;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
        .req     (bus.src_valid),
        .last    (rr_last_q),
        .grant   (arb_grant),
        .any_req (arb_any)
    );

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) beats[i] = bus.src_data[i*IN_W +: IN_W];
    end

    assign beat       = beats[gnt_q];
    assign beat_valid = bus.src_valid[gnt_q];

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_last_d   = rr_last_q;
        frame_src_d = frame_src_q;
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        shift_d     = shift_q;
        out_d       = out_q;
        ready_d     = ready_q;
        abort_d     = 1'b0;
        done_d      = '0;
        take        = '0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    gnt_d       = arb_grant;
                    rr_last_d   = arb_grant;
                    beat_cnt_d  = '0;
                    stall_cnt_d = '0;
                    state_d     = COLLECT;
                end
            end
            COLLECT: begin
                // The full count is published one cycle after the last beat; no take that cycle.
                if (beat_cnt_q == BCNT_W'(BEATS)) begin
                    state_d        = HOLD;
                    ready_d        = 1'b1;
                    out_d          = shift_q;
                    frame_src_d    = gnt_q;
                    done_d[gnt_q]  = 1'b1;
                    beat_cnt_d     = '0;
                    stall_cnt_d    = '0;
                    shift_d        = '0;
                end else if (beat_valid) begin
                    take[gnt_q] = 1'b1;
                    shift_d     = {shift_q[OUT_W-IN_W-1:0], beat};
                    beat_cnt_d  = beat_cnt_q + 1'b1;
                    stall_cnt_d = '0;
                end else if (ABORT_CYC > 0 && (32'(stall_cnt_q) + 32'd1) == 32'(ABORT_CYC)) begin
                    state_d     = IDLE;
                    beat_cnt_d  = '0;
                    stall_cnt_d = '0;
                    shift_d     = '0;
                    abort_d     = 1'b1;
                end else if (stall_cnt_q != '1) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (bus.acceptedC) begin
                    state_d = IDLE;
                    ready_d = 1'b0;
                    out_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkB or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            rr_last_q   <= SRC_W'(NUM_SRC - 1);
            frame_src_q <= '0;
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
            shift_q     <= '0;
            out_q       <= '0;
            ready_q     <= 1'b0;
            abort_q     <= 1'b0;
            done_q      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_last_q   <= rr_last_d;
            frame_src_q <= frame_src_d;
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            shift_q     <= shift_d;
            out_q       <= out_d;
            ready_q     <= ready_d;
            abort_q     <= abort_d;
            done_q      <= done_d;
        end
    end

    assign bus.src_take    = take;
    assign bus.src_done    = done_q;
    assign bus.sharedBus64 = out_q;
    assign bus.frame_src   = frame_src_q;
    assign bus.readyB      = ready_q;
    assign bus.err_abort   = abort_q;

endmodule

// File: doc/dev_packer_rr.md
Name: dev_packer_rr

Overview:
Parametrised successor to the fixed 8-to-64 collector device. Accepts narrow beats from NUM_SRC producers over a per-beat valid/take handshake, arbitrates round-robin per frame, and packs BEATS beats MSB-first into one wide word. Holds the word with readyB until the consumer accepts it. Adds stall tolerance, per-frame source tagging and a mid-frame abort timeout.

Parameters:
IN_W, 8, beat width in bits (>=1)
BEATS, 8, beats per frame (>=2); OUT_W = IN_W*BEATS
NUM_SRC, 2, number of producers (>=1); SRC_W = max(1,$clog2(NUM_SRC))
ABORT_CYC, 16, consecutive stalled COLLECT cycles before the partial frame is dropped; 0 disables the timeout

Ports:
clkB  in  1  single clock, rising edge
rst  in  1  asynchronous active-low reset
src_valid  in  NUM_SRC  per-source beat valid
src_data  in  NUM_SRC*IN_W  flattened beats; source i occupies bits [i*IN_W +: IN_W]
src_take  out  NUM_SRC  beat consumed this cycle (combinational)
src_done  out  NUM_SRC  one-cycle pulse to the granted source when its frame completes
sharedBus64  out  OUT_W  packed frame, valid while readyB=1
frame_src  out  SRC_W  index of the source that produced the frame
readyB  out  1  frame valid and held
acceptedC  in  1  consumer accept, sampled only while readyB=1
err_abort  out  1  one-cycle pulse when a partial frame is dropped

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; beat_cnt=0; stall_cnt=0; rr_last=NUM_SRC-1, so source 0 wins first; sharedBus64=0; frame_src=0; readyB=0; src_done=0; err_abort=0; shift register=0.
- All state is registered on posedge clkB. src_take is the only combinational output.
- IDLE:
  - If any src_valid is set, grant the first set bit searching from rr_last+1 with wrap.
  - Register the grant index g, set rr_last=g, go to COLLECT.
  - No beat is taken in IDLE.
- COLLECT:
  - src_take[g] = src_valid[g]. All other take bits are 0, and valid from other sources is ignored until the frame ends.
  - Each taken beat: shift <= {shift[OUT_W-IN_W-1:0], beat}; beat_cnt++; stall_cnt=0. The first beat ends in the top IN_W bits.
  - A cycle with src_valid[g]=0 holds beat_cnt and increments stall_cnt.
  - On the beat that makes beat_cnt==BEATS:
    - next cycle: state=HOLD, readyB=1, sharedBus64=final shift value, frame_src=g, src_done[g]=1 for exactly that cycle;
    - beat_cnt clears to 0.
  - Timeout (ABORT_CYC>0, stall_cnt reaches ABORT_CYC):
    - next cycle: state=IDLE, beat_cnt=0, stall_cnt=0, shift cleared, err_abort=1 for one cycle;
    - sharedBus64 unchanged; rr_last stays g, so the next arbitration favours the next source.
- HOLD:
  - readyB=1; sharedBus64 and frame_src are stable; src_take=0, so producers stall.
  - acceptedC=1 -> state IDLE; readyB=0 and sharedBus64 cleared to 0 next cycle.
  - A new grant cannot occur before the cycle after HOLD exits.
- Minimum frame latency: grant cycle + BEATS take cycles + 1, i.e. readyB rises BEATS+2 edges after the first valid when there are no stalls.
- Frame throughput: BEATS+3 cycles per frame with an immediate accept.
- beat_cnt is $clog2(BEATS+1) bits; stall_cnt is $clog2(ABORT_CYC+1) bits and saturates.
- Reset asserted mid-frame or in HOLD discards everything immediately; there is no partial output and no err_abort.
- acceptedC while not in HOLD is ignored.
- NUM_SRC=1: the arbiter degenerates to a constant grant of 0.

Decomposition:
- Package dev_pkg:
  - state enum {IDLE, COLLECT, HOLD} as a 2-bit typedef;
  - function rr_pick(req, last) returning the next index.
- One sub-module: rr_arbiter (parameter NUM_SRC; inputs req, last; output grant index and any_req; purely combinational).
- The packer FSM, counters and shift register live in dev_packer_rr.

Test Plan:
- Basic frame, defaults: source 0 presents bytes 0x01..0x08 back-to-back -> readyB after 10 edges, sharedBus64=0x0102030405060708, frame_src=0, src_done[0] pulses once; acceptedC=1 -> readyB=0 next cycle.
- Round-robin:
  - both sources valid continuously, four frames -> frame_src sequence 0,1,0,1;
  - src_take never set on the non-granted source.
- Stalls: source 1 drops valid for 3 cycles after beat 4 with data 0xA0..0xA7 -> frame 0xA0A1A2A3A4A5A6A7, readyB delayed exactly 3 cycles, no err_abort.
- Abort:
  - ABORT_CYC=4, source 0 sends 3 beats then idles -> err_abort pulses once 4 cycles after the last beat, readyB stays 0;
  - the next full frame from source 1 packs correctly with no stale bytes.
- Hold/backpressure: keep acceptedC=0 for 20 cycles in HOLD with both sources valid -> sharedBus64 stable, src_take=0 throughout; release -> the next frame proceeds.
- Reset mid-frame and parametrics:
  - drop rst after beat 5 -> all outputs 0 asynchronously, and the following frame is correct;
  - repeat the basic frame with IN_W=4, BEATS=3, NUM_SRC=3: nibbles 0xA,0xB,0xC -> 0xABC.
